// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: transmit commands, line timing,
// ns-to-cycles conversion and the receive state encoding.
package ws2812_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_TX,
    CMD_RESET
  } cmd_e;

  localparam int T0H_NS        = 400;
  localparam int T1H_NS        = 800;
  localparam int BIT_THRESH_NS = 600;
  localparam int MIN_HIGH_NS   = 200;
  localparam int MAX_HIGH_NS   = 1500;
  localparam int RESET_LOW_NS  = 50000;

  // Whole clock cycles in ns at clk_khz, never below one.
  function automatic int cycles_from_ns(
    input int ns,
    input int clk_khz
  );
    longint c;
    c = (longint'(ns) * longint'(clk_khz)) / 64'sd1000000;
    return (c < 1) ? 1 : int'(c);
  endfunction

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } rx_state_e;

endpackage

// File: rtl/ws2812_rx_decoder_if.sv
// Decoded pixel stream and frame status leaving the receiver.
// master drives it, slave consumes it.
interface ws2812_rx_decoder_if #(
  parameter int PIX_W = 8
);
  logic [7:0]       r;
  logic [7:0]       g;
  logic [7:0]       b;
  logic             pixel_valid;
  logic [PIX_W-1:0] pixel_index;
  logic             frame_done;
  logic             error;
  logic             in_sync;

  modport master (
    output r, g, b,
    output pixel_valid, pixel_index,
    output frame_done, error, in_sync
  );

  modport slave (
    input r, g, b,
    input pixel_valid, pixel_index,
    input frame_done, error, in_sync
  );
endinterface

// File: rtl/ws2812_rx_sync_edge.sv
// Two-flop synchronizer for the serial line plus
// rise/fall detection on the synchronized level.
module ws2812_rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic ds,
  output logic rise,
  output logic fall
);

  logic [1:0] meta;
  logic       prev;

  // Synchronizer chain and previous-sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      prev <= 1'b0;
    end else begin
      meta <= {meta[0], din};
      prev <= meta[1];
    end
  end

  assign ds   = meta[1];
  assign rise = ds & ~prev;
  assign fall = ~ds & prev;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 receiver: pulse-width bit decode, GRB pixel
// assembly and reset-gap frame delimiting.
module ws2812_rx_decoder
  import ws2812_pkg::*;
#(
  parameter int CLK_FREQ_KHZ = 10000,
  parameter int PIX_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  ws2812_rx_decoder_if.master px
);

  localparam int MIN_HIGH =
    cycles_from_ns(MIN_HIGH_NS, CLK_FREQ_KHZ);
  localparam int BIT_THRESH =
    cycles_from_ns(BIT_THRESH_NS, CLK_FREQ_KHZ);
  localparam int MAX_HIGH =
    cycles_from_ns(MAX_HIGH_NS, CLK_FREQ_KHZ);
  localparam int RESET_LOW =
    cycles_from_ns(RESET_LOW_NS, CLK_FREQ_KHZ);
  localparam int CW = $clog2(RESET_LOW + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t MIN_C  = cnt_t'(MIN_HIGH);
  localparam cnt_t THR_C  = cnt_t'(BIT_THRESH);
  localparam cnt_t MAX_C  = cnt_t'(MAX_HIGH);
  localparam cnt_t RL_C   = cnt_t'(RESET_LOW);
  localparam cnt_t RL1_C  = cnt_t'(RESET_LOW - 1);
  localparam cnt_t ONE_C  = cnt_t'(1);

  logic ds;
  logic rise;
  logic fall;

  ws2812_rx_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .ds   (ds),
    .rise (rise),
    .fall (fall)
  );

  rx_state_e        state, state_n;
  cnt_t             hi_cnt, hi_n;
  cnt_t             lo_cnt, lo_n;
  cnt_t             lo_inc;
  logic [4:0]       bit_cnt, bit_n;
  logic [PIX_W-1:0] pix_cnt, pix_n;
  logic [23:0]      sr, sr_n;
  logic [7:0]       r_q, r_n;
  logic [7:0]       g_q, g_n;
  logic [7:0]       b_q, b_n;
  logic [PIX_W-1:0] idx_q, idx_n;
  logic             pv_q, pv_n;
  logic             fd_q, fd_n;
  logic             err_q, err_n;

  assign lo_inc = (lo_cnt >= RL_C) ? lo_cnt
                                   : lo_cnt + ONE_C;

  // State, counters and held pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SYNC;
      hi_cnt  <= '0;
      lo_cnt  <= '0;
      bit_cnt <= '0;
      pix_cnt <= '0;
      sr      <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      pv_q    <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      hi_cnt  <= hi_n;
      lo_cnt  <= lo_n;
      bit_cnt <= bit_n;
      pix_cnt <= pix_n;
      sr      <= sr_n;
      r_q     <= r_n;
      g_q     <= g_n;
      b_q     <= b_n;
      idx_q   <= idx_n;
      pv_q    <= pv_n;
      fd_q    <= fd_n;
      err_q   <= err_n;
    end
  end

  // Next state: pulse measurement, bit shift, gap detect.
  always_comb begin
    state_n = state;
    hi_n    = hi_cnt;
    lo_n    = lo_cnt;
    bit_n   = bit_cnt;
    pix_n   = pix_cnt;
    sr_n    = sr;
    r_n     = r_q;
    g_n     = g_q;
    b_n     = b_q;
    idx_n   = idx_q;
    pv_n    = 1'b0;
    fd_n    = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      SYNC: begin
        if (ds) begin
          lo_n = '0;
        end else begin
          lo_n = lo_inc;
          if (lo_cnt >= RL1_C) state_n = IDLE;
        end
      end
      IDLE: begin
        bit_n = '0;
        pix_n = '0;
        if (rise) begin
          state_n = HIGH;
          hi_n    = ONE_C;
        end else if (!ds) begin
          lo_n = lo_inc;
        end
      end
      HIGH: begin
        if (fall) begin
          if (hi_cnt < MIN_C) begin
            err_n   = 1'b1;
            state_n = SYNC;
            lo_n    = '0;
          end else begin
            sr_n    = {sr[22:0], hi_cnt >= THR_C};
            state_n = LOW;
            lo_n    = ONE_C;
            if (bit_cnt == 5'd23) begin
              r_n   = sr_n[15:8];
              g_n   = sr_n[23:16];
              b_n   = sr_n[7:0];
              pv_n  = 1'b1;
              idx_n = pix_cnt;
              pix_n = pix_cnt + 1'b1;
              bit_n = '0;
            end else begin
              bit_n = bit_cnt + 5'd1;
            end
          end
        end else begin
          hi_n = hi_cnt + ONE_C;
          if (hi_cnt >= MAX_C) begin
            err_n   = 1'b1;
            state_n = SYNC;
            lo_n    = '0;
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_n = HIGH;
          hi_n    = ONE_C;
        end else begin
          lo_n = lo_inc;
          if (lo_cnt >= RL1_C) begin
            fd_n    = 1'b1;
            err_n   = (bit_cnt != '0);
            bit_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = SYNC;
    endcase
  end

  assign px.r           = r_q;
  assign px.g           = g_q;
  assign px.b           = b_q;
  assign px.pixel_valid = pv_q;
  assign px.pixel_index = idx_q;
  assign px.frame_done  = fd_q;
  assign px.error       = err_q;
  assign px.in_sync     = (state != SYNC);

endmodule

// File: doc/ws2812_rx_decoder.md
Name: ws2812_rx_decoder

Overview:
Receiving end of the WS2812 single-wire return-to-zero link. It samples the serial line and measures each high pulse to classify it as a 0 or 1 bit. It assembles the bits into 24-bit pixels, sent MSB first in G,R,B order, and presents each pixel as r/g/b with a one-cycle valid strobe. It detects the low-latch (reset) gap that ends a frame. It is used as the loopback checker for the transmit controller and as the input stage of a pixel-sniffer/daisy-chain bridge.

Parameters:
CLK_FREQ_KHZ, 10000, system clock frequency in kHz; all timing thresholds below are derived from it.
PIX_W, 8, width of pixel_index; the index wraps modulo 2^PIX_W.
Derived localparams (integer floor, minimum 1), with the 10 MHz value in brackets:
- MIN_HIGH = 200 ns [2]
- BIT_THRESH = 600 ns [6]
- MAX_HIGH = 1500 ns [15]
- RESET_LOW = 50000 ns [500]

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
din  in  1  asynchronous WS2812 serial line
r  out  8  red byte of last decoded pixel
g  out  8  green byte of last decoded pixel
b  out  8  blue byte of last decoded pixel
pixel_valid  out  1  one-cycle strobe; r/g/b/pixel_index are valid and stay held until the next strobe
pixel_index  out  PIX_W  position of the pixel within the current frame, 0-based
frame_done  out  1  one-cycle strobe when the reset gap is detected after at least one bit
error  out  1  one-cycle strobe on a timing violation or partial pixel
in_sync  out  1  high while the decoder is locked to frame boundaries

Behaviour:
- Single clock domain. rst is synchronous and active-high, sampled on posedge clk only.
- Reset values: r=g=b=0, pixel_valid=0, pixel_index=0, frame_done=0, error=0, in_sync=0, state=SYNC, all counters=0.
- din passes through a 2-FF synchronizer (reset to 0) followed by a prior-sample register for edge detection. Everything below uses the synchronized signal ds, which adds 2 cycles of latency.
- Counter hi_cnt counts high cycles in HIGH. Counter lo_cnt counts low cycles in SYNC/IDLE/LOW and saturates at RESET_LOW. Both are clog2(RESET_LOW+1) bits wide.
- State SYNC: in_sync=0. ds high clears lo_cnt. When lo_cnt reaches RESET_LOW, go to IDLE. No frame_done is issued from SYNC.
- State IDLE: in_sync=1. Bit count=0 and pixel_index=0. ds rising edge goes to HIGH with hi_cnt=1.
- State HIGH: hi_cnt increments while ds=1.
  - If hi_cnt exceeds MAX_HIGH: pulse error and go to SYNC; the partial pixel is discarded.
  - On a ds falling edge:
    - if hi_cnt < MIN_HIGH: pulse error and go to SYNC;
    - otherwise the bit is 1 if hi_cnt >= BIT_THRESH, else 0. Shift it into the 24-bit shift register (MSB first), increment the bit count, and go to LOW with lo_cnt=1.
- 24th bit: in the cycle after the falling edge that completes the pixel:
  - r=sr[15:8], g=sr[23:16], b=sr[7:0], pixel_valid=1;
  - pixel_index takes the current pixel count, the pixel count increments (wrapping), and the bit count returns to 0.
- State LOW: lo_cnt increments while ds=0.
  - A ds rising edge before RESET_LOW starts the next bit: go to HIGH.
  - When lo_cnt reaches RESET_LOW:
    - pulse frame_done and go to IDLE;
    - if the bit count != 0, also pulse error in the same cycle and discard the partial bits.
- The low time between bits is not bounded below RESET_LOW; a slow transmitter is accepted.
- pixel_valid and frame_done never assert in the same cycle, because 24-bit completion happens on a falling edge.
- Simultaneous rst and any event: rst wins and all outputs go to their reset values.
- rst mid-frame: the block re-enters SYNC and ignores the rest of the frame until a full RESET_LOW gap is seen.
- Power-up or reset while din is mid-frame: no pixel is emitted until the first reset gap.

Decomposition:
- Shared package ws2812_pkg holds:
  - CMD_IDLE/CMD_TX/CMD_RESET;
  - timing constants in ns (T0H 400, T1H 800, BIT_THRESH 600, MIN_HIGH 200, MAX_HIGH 1500, RESET_LOW 50000);
  - a cycles-from-ns function;
  - the rx state enum (SYNC, IDLE, HIGH, LOW).
- One sub-module, ws2812_rx_sync_edge, contains the 2-FF synchronizer, rise/fall detect and the ds output. The pulse timing and assembly stay in the top module.

Test Plan:
All scenarios run at CLK_FREQ_KHZ=10000. Bit 0 is driven as high 4 / low 8 cycles; bit 1 as high 8 / low 4 cycles.
1. Hold din low 500+ cycles, then send GRB 0x3C,0xA5,0xFF (g=3C, r=A5, b=FF), then low 500 -> in_sync=1, one pixel_valid with r=A5 g=3C b=FF pixel_index=0, then one frame_done.
2. Send three pixels 0x000001, 0x800000, 0xFFFFFF back to back, then reset gap -> pixel_valid x3, pixel_index 0,1,2, last pixel r=g=b=FF, frame_done once; the next frame restarts at index 0.
3. Send a 1-cycle high glitch after sync -> error pulse, in_sync=0, and no pixel until a 500-cycle low gap restores in_sync.
4. Send a 20-cycle high pulse -> error in the cycle where hi_cnt=16 and state SYNC; a following valid pixel is ignored until a reset gap.
5. Send 12 bits, then low 500 -> frame_done and error in the same cycle, no pixel_valid, IDLE.
6. Start driving with din mid-frame (no prior low gap), and separately assert rst for 1 cycle during bit 10 -> no pixel_valid until after a 500-cycle low gap; all outputs are 0 the cycle after rst.
